sha256_job_arbiter: RTL

Round-robin scheduler that shares one `simplified_sha256` core between `NUM_REQ` requesters. Each requester presents a message address and an output address. The arbiter grants one requester at a time, issues a one-cycle `start` to the core with the granted addresses, and tracks the core's `done` (high while the core is idle) through launch and completion. It then returns a one-cycle acknowledge, or an error if the job times out. It sits between the requester agents and the core's `start`/`message_addr`/`output_addr`/`done` pins; it does not touch the memory bus.

---
 rtl/sha256_job_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sha256_job_arbiter.sv
// Round-robin job scheduler sharing one simplified_sha256 core between NUM_REQ requesters.
// Launches the core, tracks its done handshake, and retires each job with ack (and err on timeout).
module sha256_job_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [16*NUM_REQ-1:0]        req_message_addr,
    input  logic [16*NUM_REQ-1:0]        req_output_addr,
    output logic [NUM_REQ-1:0]           ack,
    output logic [NUM_REQ-1:0]           err,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         core_start,
    output logic [15:0]                  core_message_addr,
    output logic [15:0]                  core_output_addr,
    input  logic                         core_done,
    output logic [15:0]                  job_count
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RETIRE
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 timed_out_q, timed_out_d;
    logic                 core_start_q, core_start_d;
    logic [15:0]          msg_addr_q, msg_addr_d;
    logic [15:0]          out_addr_q, out_addr_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic [NUM_REQ-1:0]   excl_q, excl_d;
    logic                 busy_q, busy_d;
    logic [15:0]          job_count_q, job_count_d;

    logic [NUM_REQ-1:0]   eligible;
    logic                 found;
    logic [IDW-1:0]       pick;
    logic [15:0]          pick_msg;
    logic [15:0]          pick_out;
    int                   sel_j;
    logic [TW-1:0]        timer_inc;
    logic                 expired;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [IDW-1:0]       rr_next;

    // The requester acked last cycle sits out exactly one IDLE cycle.
    assign eligible = req & ~excl_q;

    always_comb begin
        found    = 1'b0;
        pick     = '0;
        pick_msg = '0;
        pick_out = '0;
        sel_j    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_j = int'(rr_ptr_q) + i;
            if (sel_j >= NUM_REQ) begin
                sel_j = sel_j - NUM_REQ;
            end
            if (!found && eligible[sel_j]) begin
                found    = 1'b1;
                pick     = IDW'(sel_j);
                pick_msg = req_message_addr[16*sel_j +: 16];
                pick_out = req_output_addr[16*sel_j +: 16];
            end
        end
    end

    assign timer_inc    = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + 1'b1;
    assign expired      = (timer_inc == TW'(TIMEOUT));
    assign grant_onehot = NUM_REQ'(1) << grant_id_q;
    assign rr_next      = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        timer_d      = timer_q;
        timed_out_d  = timed_out_q;
        core_start_d = 1'b0;
        msg_addr_d   = msg_addr_q;
        out_addr_d   = out_addr_q;
        ack_d        = '0;
        err_d        = '0;
        excl_d       = ack_q;
        busy_d       = busy_q;
        job_count_d  = job_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (core_done && found) begin
                    state_d      = S_LAUNCH;
                    grant_id_d   = pick;
                    msg_addr_d   = pick_msg;
                    out_addr_d   = pick_out;
                    core_start_d = 1'b1;
                    busy_d       = 1'b1;
                    timer_d      = '0;
                    timed_out_d  = 1'b0;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_BUSY;
                timer_d = '0;
            end
            S_WAIT_BUSY: begin
                timer_d = timer_inc;
                if (expired) begin
                    state_d     = S_RETIRE;
                    timed_out_d = 1'b1;
                    ack_d       = grant_onehot;
                    err_d       = grant_onehot;
                end else if (!core_done) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                timer_d = timer_inc;
                // A completion seen on the same edge as expiry still counts as success.
                if (core_done) begin
                    state_d     = S_RETIRE;
                    ack_d       = grant_onehot;
                    job_count_d = job_count_q + 16'd1;
                end else if (expired) begin
                    state_d     = S_RETIRE;
                    timed_out_d = 1'b1;
                    ack_d       = grant_onehot;
                    err_d       = grant_onehot;
                end
            end
            S_RETIRE: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                rr_ptr_d = rr_next;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            timer_q      <= '0;
            timed_out_q  <= 1'b0;
            core_start_q <= 1'b0;
            msg_addr_q   <= '0;
            out_addr_q   <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            excl_q       <= '0;
            busy_q       <= 1'b0;
            job_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            timer_q      <= timer_d;
            timed_out_q  <= timed_out_d;
            core_start_q <= core_start_d;
            msg_addr_q   <= msg_addr_d;
            out_addr_q   <= out_addr_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            excl_q       <= excl_d;
            busy_q       <= busy_d;
            job_count_q  <= job_count_d;
        end
    end

    assign ack               = ack_q;
    assign err               = err_q;
    assign busy              = busy_q;
    assign grant_id          = grant_id_q;
    assign core_start        = core_start_q;
    assign core_message_addr = msg_addr_q;
    assign core_output_addr  = out_addr_q;
    assign job_count         = job_count_q;

endmodule
